// File: rtl/solver_ctrl_fsm.sv
// Top-level sequencer for the backtracking sudoku solver: runs IDLE -> INIT -> SOLVE -> FINISH/FAIL,
// kicks the init/solve sub-FSMs and muxes their datapath controls onto the shared address generator and mark memory.
module solver_ctrl_fsm #(
    parameter int GRID_N     = 9,
    parameter int CELL_W     = 4,
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_init_done,
    input  logic              i_solve_done,
    input  logic              i_solve_fail,
    input  logic              i_init_addr_en,
    input  logic              i_init_we_mark,
    input  logic              i_init_mark_val,
    input  logic              i_solve_addr_en,
    input  logic              i_solve_we_mark,
    input  logic              i_solve_mark_val,
    input  logic              i_store_pre_data,
    input  logic [CELL_W-1:0] i_mem_rddata,
    output logic              o_init_start,
    output logic              o_solve_start,
    output logic [1:0]        o_phase,
    output logic              o_addr_gen_en,
    output logic              o_we_mark,
    output logic              o_mark_value,
    output logic              o_get_num_from_mem,
    output logic [CELL_W-1:0] o_pre_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic              o_timeout,
    output logic [CYC_W-1:0]  o_cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SOLVE  = 3'd2,
        S_FINISH = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    // A cell value must be able to hold every digit 1..GRID_N plus the empty code 0.
    if (2**CELL_W <= GRID_N) begin : g_cell_w_too_small_for_grid_n
    end

    state_t              r_state;
    state_t              w_next;
    logic                r_init_start;
    logic                r_solve_start;
    logic                r_timeout;
    logic [CYC_W-1:0]    r_cycle_cnt;
    logic [CELL_W-1:0]   r_pre_data;
    logic                w_busy;
    logic                w_wd_expire;
    logic                w_wd_take;

    assign w_busy      = (r_state == S_INIT) || (r_state == S_SOLVE);
    assign w_wd_expire = (MAX_CYCLES != 0) && w_busy && (r_cycle_cnt == CYC_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort beats everything; in SOLVE a same-cycle done still wins over the watchdog.
    always_comb begin
        w_next    = r_state;
        w_wd_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_INIT;
            end
            S_INIT: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (w_wd_expire) begin
                    w_next    = S_FAIL;
                    w_wd_take = 1'b1;
                end else if (i_init_done) begin
                    w_next = S_SOLVE;
                end
            end
            S_SOLVE: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (i_solve_done) begin
                    w_next = S_FINISH;
                end else if (i_solve_fail) begin
                    w_next = S_FAIL;
                end else if (w_wd_expire) begin
                    w_next    = S_FAIL;
                    w_wd_take = 1'b1;
                end
            end
            S_FINISH, S_FAIL: begin
                if (i_start) w_next = S_INIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_phase            = 2'b00;
        o_addr_gen_en      = 1'b0;
        o_we_mark          = 1'b0;
        o_mark_value       = 1'b0;
        o_get_num_from_mem = 1'b0;
        o_done             = 1'b0;
        o_fail             = 1'b0;
        case (r_state)
            S_INIT: begin
                o_phase            = 2'b01;
                o_addr_gen_en      = i_init_addr_en;
                o_we_mark          = i_init_we_mark;
                o_mark_value       = i_init_mark_val;
                o_get_num_from_mem = 1'b1;
            end
            S_SOLVE: begin
                o_phase       = 2'b10;
                o_addr_gen_en = i_solve_addr_en;
                o_we_mark     = i_solve_we_mark;
                o_mark_value  = i_solve_mark_val;
            end
            S_FINISH: begin
                o_phase = 2'b11;
                o_done  = 1'b1;
            end
            S_FAIL: begin
                o_phase = 2'b11;
                o_fail  = 1'b1;
            end
            default: o_phase = 2'b00;
        endcase
    end

    // The counter freezes on the expiry cycle so a timed-out run reports MAX_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_start  <= 1'b0;
            r_solve_start <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_cnt   <= '0;
            r_pre_data    <= '0;
        end else begin
            r_init_start  <= (w_next == S_INIT) && (r_state != S_INIT);
            r_solve_start <= (w_next == S_SOLVE) && (r_state != S_SOLVE);
            if (!w_busy && (w_next == S_INIT)) begin
                r_cycle_cnt <= '0;
                r_timeout   <= 1'b0;
            end else begin
                if (w_busy && !w_wd_expire && (r_cycle_cnt != '1)) begin
                    r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
                end
                if (w_wd_take) begin
                    r_timeout <= 1'b1;
                end
            end
            if ((r_state == S_SOLVE) && i_store_pre_data) begin
                r_pre_data <= i_mem_rddata;
            end
        end
    end

    assign o_init_start  = r_init_start;
    assign o_solve_start = r_solve_start;
    assign o_busy        = w_busy;
    assign o_timeout     = r_timeout;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_pre_data    = r_pre_data;

endmodule

// File: tb/tb_solver_ctrl_fsm.sv
// Bench for solver_ctrl_fsm: three configurations driven in parallel, directed scenarios plus
// a randomized run compared against a phase-level behavioural model.
module tb_solver_ctrl_fsm;

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_SOLVE = 2;
    localparam int P_DONE  = 3;
    localparam int P_FAIL  = 4;

    typedef struct {
        int              ph;
        longint unsigned cnt;
        bit              tmo;
        logic [4:0]      pre;
        bit              ist;
        bit              sst;
    } model_t;

    logic clk = 1'b0;
    logic rst, start, abort, initDone, solveDone, solveFail;
    logic initAddrEn, initWe, initVal, solveAddrEn, solveWe, solveVal, storePre;
    logic [4:0] rdVal;

    logic [2:0] initStartO, solveStartO, addrEnO, weMarkO, markValO, getNumO;
    logic [2:0] busyO, doneO, failO, timeoutO;
    logic [1:0] phaseO [3];
    logic [31:0] cnt0;
    logic [7:0]  cnt1, cnt2;
    logic [3:0]  pre0;
    logic [2:0]  pre1;
    logic [4:0]  pre2;
    logic [11:0] flagsO [3];
    logic [31:0] cntO [3];
    logic [4:0]  preO [3];

    int errors = 0;
    int checks = 0;

    model_t mdl [3];
    int              maxCfg [3] = '{0, 16, 0};
    longint unsigned cntMaxCfg [3] = '{64'hFFFF_FFFF, 64'd255, 64'd255};
    logic [4:0]      rdMaskCfg [3] = '{5'h0F, 5'h07, 5'h1F};

    always #5 clk = ~clk;

    solver_ctrl_fsm #(.GRID_N(9), .CELL_W(4), .CYC_W(32), .MAX_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_init_done(initDone),
        .i_solve_done(solveDone), .i_solve_fail(solveFail), .i_init_addr_en(initAddrEn),
        .i_init_we_mark(initWe), .i_init_mark_val(initVal), .i_solve_addr_en(solveAddrEn),
        .i_solve_we_mark(solveWe), .i_solve_mark_val(solveVal), .i_store_pre_data(storePre),
        .i_mem_rddata(rdVal[3:0]), .o_init_start(initStartO[0]), .o_solve_start(solveStartO[0]),
        .o_phase(phaseO[0]), .o_addr_gen_en(addrEnO[0]), .o_we_mark(weMarkO[0]),
        .o_mark_value(markValO[0]), .o_get_num_from_mem(getNumO[0]), .o_pre_data(pre0),
        .o_busy(busyO[0]), .o_done(doneO[0]), .o_fail(failO[0]), .o_timeout(timeoutO[0]),
        .o_cycle_cnt(cnt0)
    );

    solver_ctrl_fsm #(.GRID_N(4), .CELL_W(3), .CYC_W(8), .MAX_CYCLES(16)) u1 (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_init_done(initDone),
        .i_solve_done(solveDone), .i_solve_fail(solveFail), .i_init_addr_en(initAddrEn),
        .i_init_we_mark(initWe), .i_init_mark_val(initVal), .i_solve_addr_en(solveAddrEn),
        .i_solve_we_mark(solveWe), .i_solve_mark_val(solveVal), .i_store_pre_data(storePre),
        .i_mem_rddata(rdVal[2:0]), .o_init_start(initStartO[1]), .o_solve_start(solveStartO[1]),
        .o_phase(phaseO[1]), .o_addr_gen_en(addrEnO[1]), .o_we_mark(weMarkO[1]),
        .o_mark_value(markValO[1]), .o_get_num_from_mem(getNumO[1]), .o_pre_data(pre1),
        .o_busy(busyO[1]), .o_done(doneO[1]), .o_fail(failO[1]), .o_timeout(timeoutO[1]),
        .o_cycle_cnt(cnt1)
    );

    solver_ctrl_fsm #(.GRID_N(16), .CELL_W(5), .CYC_W(8), .MAX_CYCLES(0)) u2 (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_init_done(initDone),
        .i_solve_done(solveDone), .i_solve_fail(solveFail), .i_init_addr_en(initAddrEn),
        .i_init_we_mark(initWe), .i_init_mark_val(initVal), .i_solve_addr_en(solveAddrEn),
        .i_solve_we_mark(solveWe), .i_solve_mark_val(solveVal), .i_store_pre_data(storePre),
        .i_mem_rddata(rdVal), .o_init_start(initStartO[2]), .o_solve_start(solveStartO[2]),
        .o_phase(phaseO[2]), .o_addr_gen_en(addrEnO[2]), .o_we_mark(weMarkO[2]),
        .o_mark_value(markValO[2]), .o_get_num_from_mem(getNumO[2]), .o_pre_data(pre2),
        .o_busy(busyO[2]), .o_done(doneO[2]), .o_fail(failO[2]), .o_timeout(timeoutO[2]),
        .o_cycle_cnt(cnt2)
    );

    for (genvar k = 0; k < 3; k++) begin : g_pack
        assign flagsO[k] = {initStartO[k], solveStartO[k], phaseO[k], addrEnO[k], weMarkO[k],
                            markValO[k], getNumO[k], busyO[k], doneO[k], failO[k], timeoutO[k]};
    end
    assign cntO[0] = cnt0;
    assign cntO[1] = {24'd0, cnt1};
    assign cntO[2] = {24'd0, cnt2};
    assign preO[0] = {1'b0, pre0};
    assign preO[1] = {2'b00, pre1};
    assign preO[2] = pre2;

    // Reference model: phases advance by the documented rules, the counter measures busy cycles.
    function automatic model_t modelStep(model_t m, int maxC, longint unsigned cntMax, logic [4:0] rdMask);
        model_t n;
        bit busy;
        bit expire;
        n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        busy   = (m.ph == P_INIT) || (m.ph == P_SOLVE);
        expire = (maxC != 0) && busy && (m.cnt == longint'(maxC) - 1);
        case (m.ph)
            P_IDLE:  if (start) n.ph = P_INIT;
            P_INIT: begin
                if (abort) n.ph = P_IDLE;
                else if (expire) begin n.ph = P_FAIL; n.tmo = 1'b1; end
                else if (initDone) n.ph = P_SOLVE;
            end
            P_SOLVE: begin
                if (abort) n.ph = P_IDLE;
                else if (solveDone) n.ph = P_DONE;
                else if (solveFail) n.ph = P_FAIL;
                else if (expire) begin n.ph = P_FAIL; n.tmo = 1'b1; end
            end
            default: if (start) n.ph = P_INIT;
        endcase
        if (busy && !expire && (m.cnt < cntMax)) n.cnt = m.cnt + 1;
        if (!busy && (n.ph == P_INIT)) begin
            n.cnt = 0;
            n.tmo = 1'b0;
        end
        if ((m.ph == P_SOLVE) && storePre) n.pre = rdVal & rdMask;
        n.ist = (n.ph == P_INIT) && (m.ph != P_INIT);
        n.sst = (n.ph == P_SOLVE) && (m.ph != P_SOLVE);
        return n;
    endfunction

    function automatic logic [11:0] expectedFlags(model_t m);
        logic [1:0] ph;
        logic a, w, v;
        ph = (m.ph == P_IDLE) ? 2'd0 : (m.ph == P_INIT) ? 2'd1 : (m.ph == P_SOLVE) ? 2'd2 : 2'd3;
        a = 1'b0; w = 1'b0; v = 1'b0;
        if (m.ph == P_INIT) begin a = initAddrEn; w = initWe; v = initVal; end
        else if (m.ph == P_SOLVE) begin a = solveAddrEn; w = solveWe; v = solveVal; end
        return {m.ist, m.sst, ph, a, w, v, (m.ph == P_INIT), (m.ph == P_INIT) || (m.ph == P_SOLVE),
                (m.ph == P_DONE), (m.ph == P_FAIL), m.tmo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        start = 0; abort = 0; initDone = 0; solveDone = 0; solveFail = 0;
        initAddrEn = 0; initWe = 0; initVal = 0; solveAddrEn = 0; solveWe = 0; solveVal = 0;
        storePre = 0; rdVal = 5'd0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        doReset();
        for (int k = 0; k < 3; k++) begin
            checks++; if (flagsO[k] !== 12'd0) begin errors++; $display("[TB] FAIL reset_flags[%0d]: got %b want 0", k, flagsO[k]); end
            checks++; if (cntO[k] !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt[%0d]: got %0d want 0", k, cntO[k]); end
            checks++; if (preO[k] !== 5'd0) begin errors++; $display("[TB] FAIL reset_pre[%0d]: got %0d want 0", k, preO[k]); end
        end
    endtask

    task automatic test_nominal_run();
        doReset();
        start = 1; tick(); start = 0;
        checks++; if (initStartO[0] !== 1'b1) begin errors++; $display("[TB] FAIL nom_init_start: got %b want 1", initStartO[0]); end
        checks++; if (phaseO[0] !== 2'd1) begin errors++; $display("[TB] FAIL nom_phase_init: got %0d want 1", phaseO[0]); end
        tick();
        checks++; if (initStartO[0] !== 1'b0) begin errors++; $display("[TB] FAIL nom_init_start_len: got %b want 0", initStartO[0]); end
        repeat (18) tick();
        initDone = 1; tick(); initDone = 0;
        checks++; if (solveStartO[0] !== 1'b1) begin errors++; $display("[TB] FAIL nom_solve_start_c21: got %b want 1", solveStartO[0]); end
        checks++; if (phaseO[0] !== 2'd2) begin errors++; $display("[TB] FAIL nom_phase_solve: got %0d want 2", phaseO[0]); end
        repeat (29) tick();
        solveDone = 1; tick(); solveDone = 0;
        checks++; if (doneO[0] !== 1'b1) begin errors++; $display("[TB] FAIL nom_done_c51: got %b want 1", doneO[0]); end
        checks++; if (cntO[0] !== 32'd50) begin errors++; $display("[TB] FAIL nom_cycle_cnt: got %0d want 50", cntO[0]); end
        tick();
        checks++; if ({doneO[0], busyO[0], phaseO[0]} !== 4'b1011) begin errors++; $display("[TB] FAIL nom_finish_hold: got %b want 1011", {doneO[0], busyO[0], phaseO[0]}); end
        checks++; if (cntO[0] !== 32'd50) begin errors++; $display("[TB] FAIL nom_cnt_hold: got %0d want 50", cntO[0]); end
    endtask

    task automatic test_watchdog();
        doReset();
        start = 1; tick(); start = 0;
        repeat (15) tick();
        checks++; if ({busyO[1], failO[1]} !== 2'b10) begin errors++; $display("[TB] FAIL wd_before_expiry: got %b want 10", {busyO[1], failO[1]}); end
        checks++; if (cntO[1] !== 32'd15) begin errors++; $display("[TB] FAIL wd_cnt_before: got %0d want 15", cntO[1]); end
        tick();
        checks++; if ({failO[1], timeoutO[1], busyO[1]} !== 3'b110) begin errors++; $display("[TB] FAIL wd_expired: got %b want 110", {failO[1], timeoutO[1], busyO[1]}); end
        checks++; if (cntO[1] !== 32'd15) begin errors++; $display("[TB] FAIL wd_cnt_frozen: got %0d want 15", cntO[1]); end
        checks++; if ({busyO[0], timeoutO[0]} !== 2'b10 || cntO[0] !== 32'd16) begin errors++; $display("[TB] FAIL wd_disabled: got busy/tmo %b cnt %0d want 10 16", {busyO[0], timeoutO[0]}, cntO[0]); end
        start = 1; tick(); start = 0;
        checks++; if ({initStartO[1], timeoutO[1], failO[1]} !== 3'b100 || cntO[1] !== 32'd0) begin errors++; $display("[TB] FAIL wd_restart: got %b cnt %0d want 100 0", {initStartO[1], timeoutO[1], failO[1]}, cntO[1]); end
        doReset();
        start = 1; tick(); start = 0;
        initDone = 1; tick(); initDone = 0;
        repeat (14) tick();
        solveDone = 1; tick(); solveDone = 0;
        checks++; if ({doneO[1], failO[1], timeoutO[1]} !== 3'b100) begin errors++; $display("[TB] FAIL wd_done_wins: got %b want 100", {doneO[1], failO[1], timeoutO[1]}); end
        checks++; if (cntO[1] !== 32'd15) begin errors++; $display("[TB] FAIL wd_done_cnt: got %0d want 15", cntO[1]); end
    endtask

    task automatic test_solve_fail_restart();
        doReset();
        start = 1; tick(); start = 0;
        initDone = 1; tick(); initDone = 0;
        repeat (3) tick();
        solveFail = 1; tick(); solveFail = 0;
        checks++; if ({failO[0], timeoutO[0], phaseO[0]} !== 4'b1011) begin errors++; $display("[TB] FAIL sf_fail_state: got %b want 1011", {failO[0], timeoutO[0], phaseO[0]}); end
        checks++; if (cntO[0] !== 32'd5) begin errors++; $display("[TB] FAIL sf_cnt: got %0d want 5", cntO[0]); end
        tick();
        start = 1; tick();
        checks++; if ({initStartO[0], phaseO[0], failO[0]} !== 4'b1010 || cntO[0] !== 32'd0) begin errors++; $display("[TB] FAIL sf_restart: got %b cnt %0d want 1010 0", {initStartO[0], phaseO[0], failO[0]}, cntO[0]); end
        tick(); start = 0;
        checks++; if ({initStartO[0], phaseO[0]} !== 3'b001 || cntO[0] !== 32'd1) begin errors++; $display("[TB] FAIL busy_start_ignored: got %b cnt %0d want 001 1", {initStartO[0], phaseO[0]}, cntO[0]); end
    endtask

    task automatic test_abort();
        doReset();
        start = 1; tick(); start = 0;
        initAddrEn = 1; initWe = 0; initVal = 1; #1;
        checks++; if ({addrEnO[0], weMarkO[0], markValO[0], getNumO[0]} !== 4'b1011) begin errors++; $display("[TB] FAIL mux_init: got %b want 1011", {addrEnO[0], weMarkO[0], markValO[0], getNumO[0]}); end
        initDone = 1; tick(); initDone = 0;
        solveAddrEn = 1; solveWe = 1; solveVal = 1; #1;
        checks++; if ({addrEnO[0], weMarkO[0], markValO[0], getNumO[0]} !== 4'b1110) begin errors++; $display("[TB] FAIL mux_solve: got %b want 1110", {addrEnO[0], weMarkO[0], markValO[0], getNumO[0]}); end
        abort = 1; tick(); abort = 0;
        checks++; if ({busyO[0], phaseO[0], addrEnO[0], weMarkO[0], markValO[0]} !== 6'd0) begin errors++; $display("[TB] FAIL abort_idle: got %b want 000000", {busyO[0], phaseO[0], addrEnO[0], weMarkO[0], markValO[0]}); end
        checks++; if (cntO[0] !== 32'd2) begin errors++; $display("[TB] FAIL abort_cnt_hold: got %0d want 2", cntO[0]); end
        start = 1; tick(); start = 0;
        initDone = 1; tick(); initDone = 0;
        solveDone = 1; abort = 1; tick(); solveDone = 0; abort = 0;
        checks++; if ({doneO[0], phaseO[0], busyO[0]} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_beats_done: got %b want 0000", {doneO[0], phaseO[0], busyO[0]}); end
        clearInputs();
    endtask

    task automatic test_pre_data();
        doReset();
        storePre = 1; rdVal = 5'd3; tick();
        checks++; if (preO[0] !== 5'd0) begin errors++; $display("[TB] FAIL pre_idle_ignored: got %0d want 0", preO[0]); end
        storePre = 0;
        start = 1; tick(); start = 0;
        initDone = 1; tick(); initDone = 0;
        storePre = 1; rdVal = 5'd7; tick(); storePre = 0;
        checks++; if (preO[0] !== 5'd7) begin errors++; $display("[TB] FAIL pre_capture: got %0d want 7", preO[0]); end
        solveFail = 1; tick(); solveFail = 0;
        start = 1; tick(); start = 0;
        storePre = 1; rdVal = 5'd5; tick(); storePre = 0;
        checks++; if (preO[0] !== 5'd7 || phaseO[0] !== 2'd1) begin errors++; $display("[TB] FAIL pre_init_ignored: got %0d phase %0d want 7 1", preO[0], phaseO[0]); end
    endtask

    task automatic test_reset_mid_run();
        doReset();
        start = 1; tick(); start = 0;
        initDone = 1; tick(); initDone = 0;
        storePre = 1; rdVal = 5'd6; tick();
        rst = 1; start = 1; solveDone = 1; solveAddrEn = 1; solveWe = 1; solveVal = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (flagsO[k] !== 12'd0 || cntO[k] !== 32'd0 || preO[k] !== 5'd0) begin
                errors++; $display("[TB] FAIL rst_mid_run[%0d]: got flags %b cnt %0d pre %0d want all 0", k, flagsO[k], cntO[k], preO[k]);
            end
        end
        rst = 0;
        clearInputs();
    endtask

    task automatic test_counter_saturation();
        doReset();
        start = 1; tick(); start = 0;
        initDone = 1; tick(); initDone = 0;
        repeat (299) tick();
        checks++; if (cntO[2] !== 32'd255 || busyO[2] !== 1'b1) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d busy %b want 255 1", cntO[2], busyO[2]); end
        checks++; if (cntO[0] !== 32'd300) begin errors++; $display("[TB] FAIL cnt_wide: got %0d want 300", cntO[0]); end
    endtask

    task automatic test_random();
        model_t nxt [3];
        doReset();
        for (int k = 0; k < 3; k++) mdl[k] = '{default: 0};
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(99) == 0);
            start       = ($urandom_range(3) == 0);
            abort       = ($urandom_range(29) == 0);
            initDone    = ($urandom_range(7) == 0);
            solveDone   = ($urandom_range(19) == 0);
            solveFail   = ($urandom_range(24) == 0);
            initAddrEn  = 1'($urandom); initWe = 1'($urandom); initVal = 1'($urandom);
            solveAddrEn = 1'($urandom); solveWe = 1'($urandom); solveVal = 1'($urandom);
            storePre    = 1'($urandom);
            rdVal       = 5'($urandom);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++; if (flagsO[k] !== expectedFlags(mdl[k])) begin errors++; $display("[TB] FAIL rnd_flags[%0d] i=%0d: got %b want %b", k, i, flagsO[k], expectedFlags(mdl[k])); end
                checks++; if (cntO[k] !== mdl[k].cnt[31:0]) begin errors++; $display("[TB] FAIL rnd_cnt[%0d] i=%0d: got %0d want %0d", k, i, cntO[k], mdl[k].cnt[31:0]); end
                checks++; if (preO[k] !== mdl[k].pre) begin errors++; $display("[TB] FAIL rnd_pre[%0d] i=%0d: got %0d want %0d", k, i, preO[k], mdl[k].pre); end
                nxt[k] = modelStep(mdl[k], maxCfg[k], cntMaxCfg[k], rdMaskCfg[k]);
            end
            tick();
            for (int k = 0; k < 3; k++) mdl[k] = nxt[k];
        end
        rst = 0;
        clearInputs();
    endtask

    initial begin
        rst = 1;
        clearInputs();
        test_reset();
        test_nominal_run();
        test_watchdog();
        test_solve_fail_restart();
        test_abort();
        test_pre_data();
        test_reset_mid_run();
        test_counter_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
